// File: rtl/elevator_call_scheduler.sv
// SCAN-style call scheduler for a 4-floor car: latches calls, sequences travel and door timers.
// Latency: door opens the cycle after a call at an idle floor; no backpressure, calls sampled every cycle.
module elevator_call_scheduler #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 6,
    parameter int TMR_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] call,
    input  logic       door_hold,
    output logic [1:0] floor,
    output logic       dir,
    output logic       moving,
    output logic       door_open,
    output logic       arrive,
    output logic [3:0] pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0] TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0] DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

    state_t           state, state_nxt;
    logic [1:0]       floor_nxt;
    logic             dir_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             arrive_nxt;
    logic [3:0]       clr;
    logic [3:0]       req;
    logic [3:0]       floor_oh;
    logic [3:0]       next_oh;
    logic [1:0]       step_floor;
    logic             above;
    logic             below;

    // Same-cycle calls count as requests so an idle car reacts on the very next edge.
    assign req        = pending | call;
    assign floor_oh   = 4'b0001 << floor;
    assign above      = |(req & (4'b1110 << floor));
    assign below      = |(req & ~(4'b1111 << floor));
    assign step_floor = dir ? (floor - 2'd1) : (floor + 2'd1);
    assign next_oh    = 4'b0001 << step_floor;

    assign moving    = (state == MOVE);
    assign door_open = (state == DOOR);

    always_comb begin
        state_nxt  = state;
        floor_nxt  = floor;
        dir_nxt    = dir;
        timer_nxt  = timer;
        arrive_nxt = 1'b0;
        clr        = 4'b0000;
        case (state)
            IDLE: begin
                if (req[floor]) begin
                    state_nxt = DOOR;
                    clr       = floor_oh;
                    timer_nxt = DOOR_LOAD;
                end else if (above && (!dir || !below)) begin
                    dir_nxt   = 1'b0;
                    state_nxt = MOVE;
                    timer_nxt = TRAVEL_LOAD;
                end else if (below) begin
                    dir_nxt   = 1'b1;
                    state_nxt = MOVE;
                    timer_nxt = TRAVEL_LOAD;
                end
            end
            MOVE: begin
                if (timer != '0) begin
                    timer_nxt = timer - TMR_ONE;
                end else begin
                    floor_nxt  = step_floor;
                    arrive_nxt = 1'b1;
                    if (|(req & next_oh)) begin
                        state_nxt = DOOR;
                        clr       = next_oh;
                        timer_nxt = DOOR_LOAD;
                    end else begin
                        timer_nxt = TRAVEL_LOAD;
                    end
                end
            end
            DOOR: begin
                // A call for the floor the door is already open at only extends the dwell.
                clr = floor_oh;
                if (door_hold || call[floor]) begin
                    timer_nxt = DOOR_LOAD;
                end else if (timer != '0) begin
                    timer_nxt = timer - TMR_ONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            floor   <= 2'd0;
            dir     <= 1'b0;
            timer   <= '0;
            arrive  <= 1'b0;
            pending <= 4'b0000;
        end else begin
            state   <= state_nxt;
            floor   <= floor_nxt;
            dir     <= dir_nxt;
            timer   <= timer_nxt;
            arrive  <= arrive_nxt;
            pending <= req & ~clr;
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] call;
    logic       door_hold;
    logic [1:0] floor;
    logic       dir;
    logic       moving;
    logic       door_open;
    logic       arrive;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    elevator_call_scheduler #(
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (3),
        .TMR_W        (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .call     (call),
        .door_hold(door_hold),
        .floor    (floor),
        .dir      (dir),
        .moving   (moving),
        .door_open(door_open),
        .arrive   (arrive),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        call = 4'b0000;
        door_hold = 1'b0;
        tickn(2);
        chk("rst_floor", 8'(floor), 8'd0);
        chk("rst_dir", 8'(dir), 8'd0);
        chk("rst_moving", 8'(moving), 8'd0);
        chk("rst_door", 8'(door_open), 8'd0);
        chk("rst_arrive", 8'(arrive), 8'd0);
        chk("rst_pending", 8'(pending), 8'd0);
        rst = 1'b0;
        tick();

        // Call at the idle floor: door opens next cycle for 3 cycles.
        call = 4'b0001;
        tick();
        call = 4'b0000;
        chk("t1_door_c1", 8'(door_open), 8'd1);
        chk("t1_pending", 8'(pending), 8'd0);
        tick();
        chk("t1_door_c2", 8'(door_open), 8'd1);
        tick();
        chk("t1_door_c3", 8'(door_open), 8'd1);
        tick();
        chk("t1_door_c4", 8'(door_open), 8'd0);
        chk("t1_moving_c4", 8'(moving), 8'd0);

        // Call two floors up.
        call = 4'b0100;
        tick();
        call = 4'b0000;
        chk("t2_moving_c1", 8'(moving), 8'd1);
        chk("t2_floor_c1", 8'(floor), 8'd0);
        chk("t2_pending_c1", 8'(pending), 8'h4);
        tickn(3);
        chk("t2_floor_c4", 8'(floor), 8'd0);
        chk("t2_arrive_c4", 8'(arrive), 8'd0);
        tick();
        chk("t2_floor_c5", 8'(floor), 8'd1);
        chk("t2_arrive_c5", 8'(arrive), 8'd1);
        tick();
        chk("t2_arrive_c6", 8'(arrive), 8'd0);
        tickn(3);
        chk("t2_floor_c9", 8'(floor), 8'd2);
        chk("t2_door_c9", 8'(door_open), 8'd1);
        chk("t2_moving_c9", 8'(moving), 8'd0);
        chk("t2_pending_c9", 8'(pending), 8'd0);

        // Door hold for 5 cycles at floor 2.
        door_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_door_held", 8'(door_open), 8'd1);
        end
        door_hold = 1'b0;
        tick();
        chk("t4_door_rel1", 8'(door_open), 8'd1);
        tick();
        chk("t4_door_rel2", 8'(door_open), 8'd1);
        tick();
        chk("t4_door_closed", 8'(door_open), 8'd0);

        // Reset in the middle of a move from floor 2 toward 3.
        call = 4'b1001;
        tick();
        call = 4'b0000;
        chk("t6_moving", 8'(moving), 8'd1);
        chk("t6_dir", 8'(dir), 8'd0);
        chk("t6_pending", 8'(pending), 8'h9);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_floor", 8'(floor), 8'd0);
        chk("t6_rst_pending", 8'(pending), 8'd0);
        chk("t6_rst_moving", 8'(moving), 8'd0);
        chk("t6_rst_dir", 8'(dir), 8'd0);
        chk("t6_rst_door", 8'(door_open), 8'd0);
        rst = 1'b0;
        tick();

        // Park at floor 1 heading UP.
        call = 4'b0010;
        tick();
        call = 4'b0000;
        tickn(4);
        chk("t5_setup_floor", 8'(floor), 8'd1);
        chk("t5_setup_door", 8'(door_open), 8'd1);
        tickn(3);
        chk("t5_setup_idle", 8'(door_open), 8'd0);
        chk("t5_setup_dir", 8'(dir), 8'd0);

        // Calls above and below together while heading UP: serve 3 first, then 0.
        call = 4'b1001;
        tick();
        call = 4'b0000;
        chk("t5_moving", 8'(moving), 8'd1);
        chk("t5_dir_up", 8'(dir), 8'd0);
        chk("t5_pending", 8'(pending), 8'h9);
        tickn(8);
        chk("t5_floor3", 8'(floor), 8'd3);
        chk("t5_door3", 8'(door_open), 8'd1);
        chk("t5_pending3", 8'(pending), 8'h1);
        tickn(4);
        chk("t5_rev_moving", 8'(moving), 8'd1);
        chk("t5_rev_dir", 8'(dir), 8'd1);
        tickn(12);
        chk("t5_floor0", 8'(floor), 8'd0);
        chk("t5_door0", 8'(door_open), 8'd1);
        chk("t5_pending0", 8'(pending), 8'd0);

        // Back up to floor 1.
        tickn(3);
        call = 4'b0010;
        tick();
        call = 4'b0000;
        chk("t3_setup_dir", 8'(dir), 8'd0);
        tickn(4);
        chk("t3_setup_floor", 8'(floor), 8'd1);
        tickn(3);

        // Heading to 3, floor-0 call arrives while passing floor 2.
        call = 4'b1000;
        tick();
        call = 4'b0000;
        chk("t3_moving", 8'(moving), 8'd1);
        tickn(4);
        call = 4'b0001;
        chk("t3_floor2", 8'(floor), 8'd2);
        chk("t3_arrive2", 8'(arrive), 8'd1);
        chk("t3_moving2", 8'(moving), 8'd1);
        tick();
        call = 4'b0000;
        chk("t3_pending", 8'(pending), 8'h9);
        tickn(3);
        chk("t3_floor3", 8'(floor), 8'd3);
        chk("t3_door3", 8'(door_open), 8'd1);
        chk("t3_dir3", 8'(dir), 8'd0);
        tickn(4);
        chk("t3_restart_moving", 8'(moving), 8'd1);
        chk("t3_restart_dir", 8'(dir), 8'd1);
        chk("t3_restart_floor", 8'(floor), 8'd3);
        tickn(12);
        chk("t3_floor0", 8'(floor), 8'd0);
        chk("t3_door0", 8'(door_open), 8'd1);
        chk("t3_pending0", 8'(pending), 8'd0);

        // Re-call of the open floor extends the door without latching.
        tick();
        call = 4'b0001;
        tick();
        call = 4'b0000;
        chk("recall_pending", 8'(pending), 8'd0);
        tickn(2);
        chk("recall_door_open", 8'(door_open), 8'd1);
        tick();
        chk("recall_door_closed", 8'(door_open), 8'd0);
        chk("recall_moving", 8'(moving), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
